// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: word RAM with byte-lane writes behind valid/ready request and
// response handshakes, with LATENCY wait states between accept and response.
module riscv_dmem_resp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_BIT = 10,
    parameter int unsigned LATENCY  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_wr_en,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [3:0]      i_req_byte_sel,
    input  logic [XLEN-1:0] i_req_wr_data,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rd_data,
    output logic            o_rsp_err
);

    localparam int unsigned Depth   = 2 ** (ADDR_BIT - 2);
    localparam int unsigned IdxW    = ADDR_BIT - 2;
    localparam logic [2:0]  LastCnt = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              req_ready_q;
    logic              wr_en_q;
    logic [XLEN-1:2]   addr_q;
    logic [3:0]        sel_q;
    logic [XLEN-1:0]   wdata_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [XLEN-1:0]   mem [Depth];

    logic              accept;
    logic              enter_resp;
    logic              do_write;
    logic              cur_wr_en;
    logic [XLEN-1:2]   cur_addr;
    logic [3:0]        cur_sel;
    logic [XLEN-1:0]   cur_wdata;
    logic              cur_err;
    logic [IdxW-1:0]   idx;
    logic [XLEN-1:0]   lane_mask;
    logic [1:0]        unused_addr_lo;

    assign unused_addr_lo = i_req_addr[1:0];
    assign accept         = i_req_valid & req_ready_q;

    // In IDLE the request is still on the inputs; with LATENCY=0 it commits on the accept edge.
    assign cur_wr_en = (state_q == StIdle) ? i_req_wr_en          : wr_en_q;
    assign cur_addr  = (state_q == StIdle) ? i_req_addr[XLEN-1:2] : addr_q;
    assign cur_sel   = (state_q == StIdle) ? i_req_byte_sel       : sel_q;
    assign cur_wdata = (state_q == StIdle) ? i_req_wr_data        : wdata_q;

    assign cur_err  = (cur_addr[XLEN-1:ADDR_BIT] != '0) || (cur_sel == 4'b0000);
    assign idx      = cur_addr[ADDR_BIT-1:2];
    assign do_write = enter_resp && cur_wr_en && !cur_err;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{cur_sel[i]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_resp  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rd_data_d   = rd_data_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = 3'd0;
                    if (LATENCY == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == LastCnt) begin
                    state_d    = StResp;
                    cnt_d      = 3'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rd_data_d   = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_err;
            rd_data_d   = (cur_err || cur_wr_en) ? '0 : (mem[idx] & lane_mask);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            req_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            sel_q       <= 4'b0000;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == StIdle);
            rsp_valid_q <= rsp_valid_d;
            rd_data_q   <= rd_data_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                wr_en_q <= i_req_wr_en;
                addr_q  <= i_req_addr[XLEN-1:2];
                sel_q   <= i_req_byte_sel;
                wdata_q <= i_req_wr_data;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_sel[i]) begin
                    mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rd_data = rd_data_q;
    assign o_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: transaction-level model checked every cycle on a LATENCY=2
// instance, plus directed back-to-back traffic on a LATENCY=0 instance.
module tb_riscv_dmem_resp;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        req_valid = 0, req_wr_en = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_sel = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rd_data;

    logic        req_valid0 = 0, req_wr_en0 = 0, rsp_ready0 = 0;
    logic [31:0] req_addr0 = 0, req_wdata0 = 0;
    logic [3:0]  req_sel0 = 0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rd_data0;

    riscv_dmem_resp #(.XLEN(32), .ADDR_BIT(10), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr_en(req_wr_en),
        .i_req_addr(req_addr), .i_req_byte_sel(req_sel), .i_req_wr_data(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rd_data(rsp_rd_data),
        .o_rsp_err(rsp_err)
    );

    riscv_dmem_resp #(.XLEN(32), .ADDR_BIT(10), .LATENCY(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0), .i_req_wr_en(req_wr_en0),
        .i_req_addr(req_addr0), .i_req_byte_sel(req_sel0), .i_req_wr_data(req_wdata0),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0), .o_rsp_rd_data(rsp_rd_data0),
        .o_rsp_err(rsp_err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one outstanding request, committed LAT+1 cycles after accept.
    logic [31:0] mmem [256];
    logic        m_up = 0, m_pend = 0, m_done = 0;
    int          m_due = 0;
    logic        m_wr, m_err;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_sel;
    logic        exp_valid, exp_ready;

    always @(negedge clk) begin
        if (rst) begin
            m_up   = 0;
            m_pend = 0;
            chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_rd_data", rsp_rd_data, 32'd0);
            chk("rst_err", {31'b0, rsp_err}, 32'd0);
        end else begin
            exp_valid = m_pend && (cyc >= m_due);
            exp_ready = m_up && !m_pend;
            if (exp_valid && !m_done) begin
                m_done = 1;
                m_err  = ((m_addr >> 10) != 0) || (m_sel == 4'b0000);
                m_rd   = 32'd0;
                if (!m_err) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_sel[i]) begin
                            if (m_wr) mmem[m_addr[9:2]][8*i +: 8] = m_wdata[8*i +: 8];
                            else      m_rd[8*i +: 8] = mmem[m_addr[9:2]][8*i +: 8];
                        end
                    end
                end
            end
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
            chk("rsp_rd_data", rsp_rd_data, exp_valid ? m_rd : 32'd0);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_valid ? m_err : 1'b0});
            if (exp_valid && rsp_ready) begin
                m_pend = 0;
            end else if (exp_ready && req_valid) begin
                m_pend  = 1;
                m_done  = 0;
                m_due   = cyc + 1 + LAT;
                m_wr    = req_wr_en;
                m_addr  = req_addr;
                m_sel   = req_sel;
                m_wdata = req_wdata;
            end
            m_up = 1;
        end
    end

    // Called in the window just after a rising edge; returns in the same window.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input int stall,
                        output logic [31:0] rd, output logic err, output int lat);
        int acc_cyc;
        bit ok;
        rd = 32'hx; err = 1'bx; lat = -1;
        req_valid = 1; req_wr_en = wr; req_addr = addr; req_sel = sel; req_wdata = wdata;
        rsp_ready = (stall == 0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 0; req_wr_en = ~wr; req_addr = 32'h3FC; req_sel = 4'hF;
        req_wdata = 32'hFFFF_FFFF;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            rsp_ready = 0;
            return;
        end
        acc_cyc = cyc;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
            if (!ok) begin @(posedge clk); #1; end
        end
        if (!ok) begin
            chk("response_timeout", 32'd0, 32'd1);
            rsp_ready = 0;
            return;
        end
        rd  = rsp_rd_data;
        err = rsp_err;
        lat = cyc - acc_cyc + 1;
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            rsp_ready = 1;
        end
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    logic [31:0] t6_wd  [5] = '{32'hA5A5A5A5, 32'h0, 32'h00003C00, 32'h0, 32'h0};
    logic [3:0]  t6_sel [5] = '{4'hF, 4'hF, 4'h2, 4'h3, 4'h0};
    logic        t6_wr  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] t6_rd  [5] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h00003CA5, 32'h0};
    logic        t6_err [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic t6_drive(input int k);
        req_valid0 = 1; req_wr_en0 = t6_wr[k]; req_addr0 = 32'h8;
        req_sel0 = t6_sel[k]; req_wdata0 = t6_wd[k];
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          k, r;
        int          acc_at [5];

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // T1
        xact(1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, err, lat);
        chk("t1_store_lat", 32'(lat), 32'd3);
        chk("t1_store_rd", rd, 32'd0);
        chk("t1_store_err", {31'b0, err}, 32'd0);
        xact(0, 32'h10, 4'hF, 32'h0, 0, rd, err, lat);
        chk("t1_load_lat", 32'(lat), 32'd3);
        chk("t1_load_rd", rd, 32'hDEADBEEF);
        chk("t1_load_err", {31'b0, err}, 32'd0);

        // T2
        xact(1, 32'h10, 4'b0100, 32'h00AA0000, 0, rd, err, lat);
        xact(0, 32'h10, 4'hF, 32'h0, 0, rd, err, lat);
        chk("t2_load_full", rd, 32'hDEAABEEF);
        xact(0, 32'h10, 4'b0011, 32'h0, 0, rd, err, lat);
        chk("t2_load_low", rd, 32'h0000BEEF);

        // T3
        xact(0, 32'h10, 4'hF, 32'h0, 5, rd, err, lat);
        chk("t3_stall_rd", rd, 32'hDEAABEEF);
        @(negedge clk);
        chk("t3_ready_after", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // T4
        xact(1, 32'h0, 4'hF, 32'h0BADF00D, 0, rd, err, lat);
        xact(1, 32'h400, 4'hF, 32'h12345678, 0, rd, err, lat);
        chk("t4_oor_err", {31'b0, err}, 32'd1);
        chk("t4_oor_rd", rd, 32'd0);
        xact(0, 32'h0, 4'hF, 32'h0, 0, rd, err, lat);
        chk("t4_alias_rd", rd, 32'h0BADF00D);
        xact(0, 32'h10, 4'h0, 32'h0, 0, rd, err, lat);
        chk("t4_nosel_err", {31'b0, err}, 32'd1);
        chk("t4_nosel_rd", rd, 32'd0);

        // T5
        xact(1, 32'h20, 4'hF, 32'h11111111, 0, rd, err, lat);
        req_valid = 1; req_wr_en = 1; req_addr = 32'h20; req_sel = 4'hF;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("t5_ready", {31'b0, req_ready}, 32'd0);
        chk("t5_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t5_rd", rsp_rd_data, 32'd0);
        chk("t5_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        xact(0, 32'h20, 4'hF, 32'h0, 0, rd, err, lat);
        chk("t5_load_rd", rd, 32'h11111111);

        // T6
        k = 0; r = 0;
        t6_drive(0);
        rsp_ready0 = 1;
        for (int c = 0; c < 40 && r < 5; c++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                chk("t6_rd", rsp_rd_data0, t6_rd[r]);
                chk("t6_err", {31'b0, rsp_err0}, {31'b0, t6_err[r]});
                chk("t6_lat", 32'(cyc), 32'(acc_at[r] + 1));
                r++;
            end
            if (req_ready0 && req_valid0) begin
                acc_at[k] = cyc;
                if (k > 0) chk("t6_gap", 32'(cyc - acc_at[k-1]), 32'd2);
                k++;
            end
            @(posedge clk); #1;
            if (k < 5) t6_drive(k);
            else req_valid0 = 0;
        end
        chk("t6_responses", 32'(r), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
